// File: rtl/hyperbus_wb_bridge_if.sv
// Bus bundle between a Wishbone B4 classic master, the bridge and the
// hyperbus leader controller request interface.
//   slave  : the bridge's view (Wishbone slave, controller requester)
//   master : the opposite side (Wishbone master plus controller responses)
// Signal names keep the Wishbone/controller suffixes as seen from the bridge.
interface hyperbus_wb_bridge_if #(
  parameter int ADDR_LENGTH = 32
);
  logic [31:0]            wb_adr_i;
  logic [31:0]            wb_dat_i;
  logic [3:0]             wb_sel_i;
  logic                   wb_we_i;
  logic                   wb_cyc_i;
  logic                   wb_stb_i;
  logic [31:0]            wb_dat_o;
  logic                   wb_ack_o;
  logic                   wb_err_o;
  logic [ADDR_LENGTH-1:0] hb_adr_o;
  logic [15:0]            hb_dat_o;
  logic [2:0]             hb_mask_o;
  logic [15:0]            hb_dat_i;
  logic                   hb_ready_i;
  logic                   hb_valid_i;
  logic                   hb_reg_space_o;
  logic                   hb_wrq_o;
  logic                   hb_rrq_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  hb_dat_i, hb_ready_i, hb_valid_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output hb_adr_o, hb_dat_o, hb_mask_o, hb_reg_space_o, hb_wrq_o, hb_rrq_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output hb_dat_i, hb_ready_i, hb_valid_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  hb_adr_o, hb_dat_o, hb_mask_o, hb_reg_space_o, hb_wrq_o, hb_rrq_o
  );
endinterface

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone B4 classic slave -> hyperbus leader controller bridge.
// Each 32-bit access becomes one 2-beat linear burst (16-bit beats).
// Ports:
//   clk, rstn    : controller clock, asynchronous active-low reset
//   bus          : hyperbus_wb_bridge_if.slave (Wishbone + controller request bus)
//   o_dbg_state  : current FSM state (IDLE=0, WRITE=1, READ=2, DONE=3)
// Handshake: a Wishbone access is accepted in IDLE when cyc&stb are high and
// no ack/err is pending; hb_wrq_o/hb_rrq_o stay high until the burst ends.
// A write beat is consumed on every cycle with hb_ready_i high, a read beat
// is taken on every cycle with hb_valid_i high. One transaction in flight.
module hyperbus_wb_bridge #(
  parameter int ADDR_LENGTH    = 32,
  parameter int REG_SPACE_BIT  = 31,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rstn,
  hyperbus_wb_bridge_if.slave  bus,
  output logic [1:0]           o_dbg_state
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_READ = 2'd2, S_DONE = 2'd3} state_t;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam int AW   = ADDR_LENGTH - 1;

  state_t          r_state, w_next;
  logic [AW-1:0]   r_hb_word;
  logic [31:0]     r_wdata, r_rdata;
  logic [3:0]      r_sel;
  logic            r_reg_space, r_abort;
  logic [1:0]      r_beat;
  logic [WD_W-1:0] r_wdog;
  logic            r_ack, r_err, r_wrq, r_rrq;
  logic            w_accept, w_last, w_timeout, w_respond, w_busy;
  logic [15:0]     w_hb_dat;
  logic [2:0]      w_hb_mask;

  assign w_busy    = (r_state == S_WRITE) || (r_state == S_READ);
  assign w_accept  = (r_state == S_IDLE) && bus.wb_cyc_i && bus.wb_stb_i && !r_ack && !r_err;
  assign w_last    = ((r_state == S_WRITE) && bus.hb_ready_i && (r_beat == 2'd1)) ||
                     ((r_state == S_READ)  && bus.hb_valid_i && (r_beat == 2'd1));
  // A beat completing on the same edge as the watchdog wins over the abort.
  assign w_timeout = w_busy && !w_last && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
  // A master that walked away mid-burst gets neither ack nor err.
  assign w_respond = !r_abort && bus.wb_cyc_i && bus.wb_stb_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:          if (w_accept) w_next = bus.wb_we_i ? S_WRITE : S_READ;
      S_WRITE, S_READ: if (w_last || w_timeout) w_next = S_DONE;
      S_DONE:          w_next = S_IDLE;
      default:         w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hb_word   <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_sel       <= '0;
      r_reg_space <= 1'b0;
      r_abort     <= 1'b0;
      r_beat      <= '0;
      r_wdog      <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_wrq       <= 1'b0;
      r_rrq       <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_hb_word   <= AW'(bus.wb_adr_i[31:2]);
          r_wdata     <= bus.wb_dat_i;
          r_sel       <= bus.wb_sel_i;
          r_reg_space <= bus.wb_adr_i[REG_SPACE_BIT];
          r_wrq       <= bus.wb_we_i;
          r_rrq       <= !bus.wb_we_i;
          r_wdog      <= '0;
          r_beat      <= '0;
          r_abort     <= 1'b0;
        end
        S_WRITE, S_READ: begin
          r_wdog <= r_wdog + WD_W'(1);
          if (!(bus.wb_cyc_i && bus.wb_stb_i)) r_abort <= 1'b1;
          if (r_state == S_WRITE && bus.hb_ready_i) r_beat <= r_beat + 2'd1;
          if (r_state == S_READ && bus.hb_valid_i) begin
            r_beat <= r_beat + 2'd1;
            if (r_beat == 2'd0) r_rdata[15:0]  <= bus.hb_dat_i;
            else                r_rdata[31:16] <= bus.hb_dat_i;
          end
          if (w_last || w_timeout) begin
            r_wrq <= 1'b0;
            r_rrq <= 1'b0;
            r_ack <= w_last && w_respond;
            r_err <= w_timeout && w_respond;
          end
        end
        default: r_beat <= '0;
      endcase
    end
  end

  // Beat 2 (and every non-WRITE state) presents a fully masked idle word so
  // the controller's trailing write cycle never corrupts memory.
  always_comb begin
    w_hb_dat  = 16'h0000;
    w_hb_mask = 3'b011;
    if (r_state == S_WRITE) begin
      if (r_beat == 2'd0) begin
        w_hb_dat  = r_wdata[15:0];
        w_hb_mask = {1'b0, ~r_sel[1], ~r_sel[0]};
      end else if (r_beat == 2'd1) begin
        w_hb_dat  = r_wdata[31:16];
        w_hb_mask = {1'b0, ~r_sel[3], ~r_sel[2]};
      end
    end
  end

  assign bus.wb_dat_o       = r_rdata;
  assign bus.wb_ack_o       = r_ack;
  assign bus.wb_err_o       = r_err;
  assign bus.hb_adr_o       = {r_hb_word, 1'b0};
  assign bus.hb_dat_o       = w_hb_dat;
  assign bus.hb_mask_o      = w_hb_mask;
  assign bus.hb_reg_space_o = r_reg_space;
  assign bus.hb_wrq_o       = r_wrq;
  assign bus.hb_rrq_o       = r_rrq;
  assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
module tb_hyperbus_wb_bridge;
  localparam int T = 40;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] dbg_state;
  int         errors = 0;
  int         checks = 0;
  int         ack_cnt = 0;
  int         err_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata = 32'h0;

  hyperbus_wb_bridge_if #(.ADDR_LENGTH(32)) bus();

  hyperbus_wb_bridge #(.ADDR_LENGTH(32), .REG_SPACE_BIT(31), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wb_ack_o === 1'b1) ack_cnt++;
    if (bus.wb_err_o === 1'b1) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Word address model: byte address halved, forced even.
  function automatic logic [31:0] exp_adr(input logic [31:0] a);
    return (a >> 1) & 32'hFFFF_FFFE;
  endfunction

  task automatic test_reset();
    bus.wb_adr_i = 0; bus.wb_dat_i = 0; bus.wb_sel_i = 0; bus.wb_we_i = 0;
    bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.hb_dat_i = 0; bus.hb_ready_i = 0; bus.hb_valid_i = 0;
    rstn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.wb_ack_o, bus.wb_err_o, bus.hb_wrq_o, bus.hb_rrq_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctl: got %b expected 0000", {bus.wb_ack_o, bus.wb_err_o, bus.hb_wrq_o, bus.hb_rrq_o});
    end
    checks++;
    if ({bus.wb_dat_o, bus.hb_dat_o, bus.hb_mask_o} !== {32'h0, 16'h0, 3'b011}) begin
      errors++; $display("FAIL reset_data: got %h/%h/%b expected 0/0/011", bus.wb_dat_o, bus.hb_dat_o, bus.hb_mask_o);
    end
    rstn = 1'b1;
    tick();
  endtask

  // One Wishbone write; the controller consumes two beats after random gaps.
  task automatic do_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input bit hold_stb, input bit abort);
    logic [15:0] e_dat;
    logic [2:0]  e_mask;
    bus.wb_adr_i = adr; bus.wb_dat_i = dat; bus.wb_sel_i = sel; bus.wb_we_i = 1'b1;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    tick();
    if (abort) begin bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; end
    checks++;
    if ({bus.hb_wrq_o, bus.hb_rrq_o} !== 2'b10) begin
      errors++; $display("FAIL wr_req: got %b expected 10", {bus.hb_wrq_o, bus.hb_rrq_o});
    end
    checks++;
    if (bus.hb_adr_o !== exp_adr(adr)) begin
      errors++; $display("FAIL wr_adr: got %h expected %h", bus.hb_adr_o, exp_adr(adr));
    end
    checks++;
    if (bus.hb_reg_space_o !== adr[31]) begin
      errors++; $display("FAIL wr_regspace: got %b expected %b", bus.hb_reg_space_o, adr[31]);
    end
    for (int b = 0; b < 2; b++) begin
      repeat ($urandom_range(0, 3)) begin
        bus.hb_ready_i = 1'b0;
        tick();
      end
      e_dat  = (b == 0) ? dat[15:0] : dat[31:16];
      e_mask = (b == 0) ? {1'b0, ~sel[1], ~sel[0]} : {1'b0, ~sel[3], ~sel[2]};
      checks++;
      if ({bus.hb_dat_o, bus.hb_mask_o} !== {e_dat, e_mask} || bus.hb_wrq_o !== 1'b1) begin
        errors++; $display("FAIL wr_beat%0d: got %h/%b wrq=%b expected %h/%b wrq=1", b,
                           bus.hb_dat_o, bus.hb_mask_o, bus.hb_wrq_o, e_dat, e_mask);
      end
      bus.hb_ready_i = 1'b1;
      tick();
    end
    // Controller's trailing ready cycle must see an idle, fully masked word.
    checks++;
    if ({bus.hb_wrq_o, bus.wb_ack_o, bus.wb_err_o, bus.hb_dat_o, bus.hb_mask_o} !==
        {1'b0, !abort, 1'b0, 16'h0, 3'b011}) begin
      errors++; $display("FAIL wr_done: got wrq=%b ack=%b err=%b %h/%b expected wrq=0 ack=%b err=0 0000/011",
                         bus.hb_wrq_o, bus.wb_ack_o, bus.wb_err_o, bus.hb_dat_o, bus.hb_mask_o, !abort);
    end
    bus.hb_ready_i = 1'b0;
    if (!hold_stb) begin bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; end
    tick();
    checks++;
    if ({bus.wb_ack_o, bus.hb_wrq_o} !== 2'b00) begin
      errors++; $display("FAIL wr_pulse: got ack=%b wrq=%b expected 0 0", bus.wb_ack_o, bus.hb_wrq_o);
    end
  endtask

  // One Wishbone read; gap<0 picks random gaps; extra drives a stray 3rd beat.
  task automatic do_read(input logic [31:0] adr, input logic [15:0] b0, input logic [15:0] b1,
                         input int gap, input bit extra);
    logic [31:0] e;
    exp_q.push_back({b1, b0});
    bus.wb_adr_i = adr; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'hF;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    tick();
    checks++;
    if ({bus.hb_wrq_o, bus.hb_rrq_o, bus.hb_reg_space_o} !== {2'b01, adr[31]} || bus.hb_adr_o !== exp_adr(adr)) begin
      errors++; $display("FAIL rd_req: got req=%b rs=%b adr=%h expected 01 %b %h", {bus.hb_wrq_o, bus.hb_rrq_o},
                         bus.hb_reg_space_o, bus.hb_adr_o, adr[31], exp_adr(adr));
    end
    for (int b = 0; b < 2; b++) begin
      repeat ((gap < 0) ? $urandom_range(0, 3) : gap) begin
        bus.hb_valid_i = 1'b0;
        bus.hb_dat_i = 16'($urandom);
        tick();
      end
      bus.hb_dat_i = (b == 0) ? b0 : b1;
      bus.hb_valid_i = 1'b1;
      tick();
    end
    e = exp_q.pop_front();
    checks++;
    if ({bus.wb_ack_o, bus.wb_err_o, bus.hb_rrq_o} !== 3'b100 || bus.wb_dat_o !== e) begin
      errors++; $display("FAIL rd_data: got ack=%b err=%b rrq=%b dat=%h expected 1 0 0 %h",
                         bus.wb_ack_o, bus.wb_err_o, bus.hb_rrq_o, bus.wb_dat_o, e);
    end
    bus.hb_valid_i = extra;
    bus.hb_dat_i = 16'hDEAD;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    tick();
    bus.hb_valid_i = 1'b0;
    tick();
    checks++;
    if ({bus.wb_ack_o, bus.hb_rrq_o} !== 2'b00 || bus.wb_dat_o !== e) begin
      errors++; $display("FAIL rd_after: got ack=%b rrq=%b dat=%h expected 0 0 %h",
                         bus.wb_ack_o, bus.hb_rrq_o, bus.wb_dat_o, e);
    end
    last_rdata = e;
  endtask

  task automatic test_write_full();
    do_write(32'h0000_0010, 32'hA1B2_C3D4, 4'hF, 1'b0, 1'b0);
  endtask

  task automatic test_write_partial();
    do_write(32'h0000_0104, 32'h1122_3344, 4'b0100, 1'b0, 1'b0);
    do_write(32'h0000_0200, 32'hCAFE_F00D, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_read();
    do_read(32'h0000_0020, 16'h5566, 16'h7788, 3, 1'b1);
  endtask

  task automatic test_timeout();
    int n;
    int acks0;
    int errs0;
    acks0 = ack_cnt;
    errs0 = err_cnt;
    bus.wb_adr_i = 32'h8000_0040; bus.wb_we_i = 1'b0;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    tick();
    checks++;
    if ({bus.hb_rrq_o, bus.hb_reg_space_o} !== 2'b11) begin
      errors++; $display("FAIL to_req: got rrq=%b rs=%b expected 1 1", bus.hb_rrq_o, bus.hb_reg_space_o);
    end
    n = 0;
    for (int i = 1; i <= T + 8; i++) begin
      tick();
      if (bus.wb_err_o === 1'b1) begin n = i; break; end
    end
    checks++;
    if (n != T) begin
      errors++; $display("FAIL to_cycle: got %0d expected %0d", n, T);
    end
    checks++;
    if ({bus.hb_rrq_o, bus.wb_ack_o} !== 2'b00 || bus.wb_dat_o !== last_rdata) begin
      errors++; $display("FAIL to_state: got rrq=%b ack=%b dat=%h expected 0 0 %h",
                         bus.hb_rrq_o, bus.wb_ack_o, bus.wb_dat_o, last_rdata);
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    tick();
    checks++;
    if (ack_cnt != acks0 || err_cnt != errs0 + 1) begin
      errors++; $display("FAIL to_counts: got acks=%0d errs=%0d expected %0d %0d", ack_cnt, err_cnt, acks0, errs0 + 1);
    end
  endtask

  task automatic test_back_to_back();
    int acks0;
    acks0 = ack_cnt;
    do_write(32'h0000_0300, 32'h0BAD_BEEF, 4'hF, 1'b1, 1'b0);
    do_write(32'h0000_0304, 32'h1357_9BDF, 4'b1001, 1'b0, 1'b0);
    tick();
    checks++;
    if (ack_cnt != acks0 + 2) begin
      errors++; $display("FAIL b2b_acks: got %0d expected %0d", ack_cnt - acks0, 2);
    end
  endtask

  task automatic test_abort();
    int acks0;
    acks0 = ack_cnt;
    do_write(32'h0000_0400, 32'h2468_ACE0, 4'hF, 1'b0, 1'b1);
    checks++;
    if (ack_cnt != acks0) begin
      errors++; $display("FAIL abort_ack: got %0d acks expected 0", ack_cnt - acks0);
    end
  endtask

  task automatic test_reset_mid_burst();
    bus.wb_adr_i = 32'h0000_0500; bus.wb_dat_i = 32'h9988_7766; bus.wb_sel_i = 4'hF;
    bus.wb_we_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    tick();
    bus.hb_ready_i = 1'b1;
    tick();
    bus.hb_ready_i = 1'b0;
    checks++;
    if ({bus.hb_wrq_o, bus.hb_dat_o} !== {1'b1, 16'h9988}) begin
      errors++; $display("FAIL rst_pre: got wrq=%b dat=%h expected 1 9988", bus.hb_wrq_o, bus.hb_dat_o);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.hb_wrq_o, bus.wb_ack_o, bus.hb_dat_o, bus.hb_mask_o} !== {2'b00, 16'h0, 3'b011}) begin
      errors++; $display("FAIL rst_mid: got wrq=%b ack=%b %h/%b expected 0 0 0000/011",
                         bus.hb_wrq_o, bus.wb_ack_o, bus.hb_dat_o, bus.hb_mask_o);
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    do_write(32'h0000_0504, 32'h5A5A_A5A5, 4'b0011, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom), 1'b0, 1'b0);
      else
        do_read(a, 16'($urandom), 16'($urandom), -1, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_write_full();
    test_write_partial();
    test_read();
    test_timeout();
    test_back_to_back();
    test_abort();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "time limit");
  end
endmodule
